apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Multi-requester APB4 master that shares the single APB RAM slave between NUM_REQ internal requesters.
- Round-robin arbitration, with one outstanding transfer at a time.
- Sequences the APB IDLE/SETUP/ACCESS phases, handles PREADY wait states with a timeout, and returns read data and error status to the winning requester.
- Sits between the requester logic and the APB slave pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, `APB_ADDR_WIDTH, PADDR / req address width.
- DATA_WIDTH, `APB_DATA_WIDTH, PWDATA/PRDATA width.
- STRB_WIDTH, `APB_STRB_WIDTH, PSTRB width (DATA_WIDTH/8).
- PROT_WIDTH, `APB_PROT_WIDTH, PPROT width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before forced error completion; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on its rising edge.
- PRESET  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*STRB_WIDTH  packed byte strobes.
- req_prot  in  NUM_REQ*PROT_WIDTH  packed protection attributes.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: command accepted.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete.
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid (0 for writes).
- rsp_err  out  1  error flag; valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  STRB_WIDTH; PPROT  out  PROT_WIDTH.
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESET is asynchronous and active-high.
- Reset:
  - While PRESET is high, every output is 0, the FSM is in IDLE, the round-robin pointer is 0 and the timeout counter is 0.
  - This holds when PRESET asserts mid-transfer: the transfer is abandoned and no rsp_valid is issued.
- Outputs: all outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On an edge with any req_valid high, pick the winner, latch its command into the P* registers, pulse req_ack[winner], then go to SETUP.
  - After the winner is chosen, the pointer becomes winner+1 mod NUM_REQ.
  - Once IDLE is re-entered, PADDR/PWRITE/PWDATA/PSTRB/PPROT hold their last values.
- Arbitration:
  - Round-robin, starting at the pointer and scanning upward with wrap.
  - Only requesters whose req_valid is high at the decision edge are eligible.
- SETUP: PSEL=1, PENABLE=0; always exactly one cycle, then ACCESS.
- ACCESS (PSEL=1, PENABLE=1):
  - On an edge with PREADY=1: register rsp_rdata (PRDATA if read, else 0) and rsp_err=PSLVERR, and pulse rsp_valid[winner].
  - Next state after completion: SETUP (with new arbitration and ack, as in IDLE) if any req_valid is high at that edge, else IDLE.
- Read strobe rule: for reads PSTRB is driven 0 regardless of req_strb, because the slave flags non-zero read strobes as an error. For writes PSTRB = req_strb.
- Latency:
  - Zero-wait-state transfer: req_valid seen at edge N, req_ack high in cycle N+1 (SETUP), ACCESS in cycle N+2, rsp_valid in cycle N+3.
  - Back-to-back transfers take 2 cycles each.
- Requester handshake:
  - req_valid and the command must stay stable until req_ack.
  - The requester may deassert or change them in the cycle after req_ack.
  - A requester must not re-request until its rsp_valid.
- Wait states: each ACCESS edge with PREADY=0 increments the timeout counter. The counter clears on entering SETUP.
- Timeout: when TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer completes with rsp_err=1 and rsp_rdata=0. PSEL and PENABLE deassert (go to IDLE, or to SETUP if requests are pending).
- Simultaneous events:
  - A completion edge and new requests arbitrate in the same edge.
  - A requester that is acked and completes is never acked twice for one request.
- Invariant: req_ack and rsp_valid are each at most one-hot.

Test Plan:
- Write then read: req0 writes addr 0x05, data 0xDEADBEEF, strb 4'hF; then reads 0x05. Required: PSEL/PENABLE sequence 10→11, rsp_valid[0] 3 cycles after the edge where req_valid is first sampled, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read strobe forcing: req1 reads with req_strb=4'hF. Required: PSTRB=0 during SETUP/ACCESS and rsp_err=0.
- Contention: req0 and req1 both hold valid continuously for 4 requests each. Required: acks alternate 0,1,0,1, with transfers back-to-back and no IDLE cycle between them.
- Wait states: slave holds PREADY=0 for 3 ACCESS cycles, then returns PREADY=1 with PSLVERR=1. Required: PENABLE stays high for 4 cycles, then rsp_valid with rsp_err=1.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck at 0. Required: rsp_valid with rsp_err=1 and rsp_rdata=0 after 4 ACCESS cycles, and PSEL=0 on the next cycle.
- Reset mid-ACCESS: assert PRESET asynchronously between edges during ACCESS. Required: all outputs 0 immediately, no rsp_valid, and the pointer restarts at requester 0.

Source files
------------

// File: rtl/apb_rr_master.sv
// Purpose: APB4 master sharing one slave between NUM_REQ requesters with round-robin arbitration.
// Latency: req_valid seen at edge N -> req_ack in N+1 (SETUP), ACCESS in N+2, rsp_valid in N+3 with zero waits.
// Backpressure: PREADY low stretches ACCESS; TIMEOUT_CYCLES consecutive waits force an error completion.

`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 12
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif
`ifndef APB_PROT_WIDTH
`define APB_PROT_WIDTH 3
`endif

module apb_rr_master #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
   parameter int STRB_WIDTH     = `APB_STRB_WIDTH,
   parameter int PROT_WIDTH     = `APB_PROT_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
   input  logic [NUM_REQ*PROT_WIDTH-1:0]  req_prot,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic                           rsp_err,
   output logic                           PSEL,
   output logic                           PENABLE,
   output logic                           PWRITE,
   output logic [ADDR_WIDTH-1:0]          PADDR,
   output logic [DATA_WIDTH-1:0]          PWDATA,
   output logic [STRB_WIDTH-1:0]          PSTRB,
   output logic [PROT_WIDTH-1:0]          PPROT,
   input  logic [DATA_WIDTH-1:0]          PRDATA,
   input  logic                           PREADY,
   input  logic                           PSLVERR
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                  state, state_n;
   logic [PW-1:0]           ptr, ptr_n, owner, owner_n, win;
   logic [CW-1:0]           tcnt, tcnt_n;
   logic                    found, grant, complete, timeout_hit;
   logic                    psel_n, pen_n, pwrite_n, err_n;
   logic [ADDR_WIDTH-1:0]   paddr_n;
   logic [DATA_WIDTH-1:0]   pwdata_n, rdata_n;
   logic [STRB_WIDTH-1:0]   pstrb_n;
   logic [PROT_WIDTH-1:0]   pprot_n;
   logic [NUM_REQ-1:0]      ack_n, rspv_n;

   // Completion happens on PREADY, or on the wait that would reach the timeout limit.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && !PREADY && (tcnt == CW'(TIMEOUT_CYCLES - 1));
   assign complete    = (state == ACCESS) && (PREADY || timeout_hit);
   assign grant       = found && ((state == IDLE) || complete);

   // Round-robin scan: first valid requester at or above the pointer, wrapping.
   always_comb begin : arb
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_n  = state;
      psel_n   = PSEL;
      pen_n    = PENABLE;
      pwrite_n = PWRITE;
      paddr_n  = PADDR;
      pwdata_n = PWDATA;
      pstrb_n  = PSTRB;
      pprot_n  = PPROT;
      ack_n    = '0;
      rspv_n   = '0;
      rdata_n  = rsp_rdata;
      err_n    = rsp_err;
      ptr_n    = ptr;
      owner_n  = owner;
      tcnt_n   = tcnt;
      case (state)
         IDLE: begin
            psel_n = 1'b0;
            pen_n  = 1'b0;
         end
         SETUP: begin
            state_n = ACCESS;
            pen_n   = 1'b1;
         end
         ACCESS: begin
            if (complete) begin
               rspv_n[owner] = 1'b1;
               rdata_n       = (PREADY && !PWRITE) ? PRDATA : '0;
               err_n         = PREADY ? PSLVERR : 1'b1;
               state_n       = IDLE;
               psel_n        = 1'b0;
               pen_n         = 1'b0;
            end else begin
               tcnt_n = tcnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      // A new winner can be taken from IDLE or on the completion edge itself.
      if (grant) begin
         state_n     = SETUP;
         psel_n      = 1'b1;
         pen_n       = 1'b0;
         pwrite_n    = req_write[win];
         paddr_n     = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
         pwdata_n    = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
         // Reads carry zero strobes; the slave rejects anything else.
         pstrb_n     = req_write[win] ? req_strb[win*STRB_WIDTH +: STRB_WIDTH] : '0;
         pprot_n     = req_prot[win*PROT_WIDTH +: PROT_WIDTH];
         ack_n[win]  = 1'b1;
         ptr_n       = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
         owner_n     = win;
         tcnt_n      = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_n;
   end

   // Registered outputs, arbitration pointer, owner and wait counter.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         PPROT     <= '0;
         req_ack   <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         ptr       <= '0;
         owner     <= '0;
         tcnt      <= '0;
      end else begin
         PSEL      <= psel_n;
         PENABLE   <= pen_n;
         PWRITE    <= pwrite_n;
         PADDR     <= paddr_n;
         PWDATA    <= pwdata_n;
         PSTRB     <= pstrb_n;
         PPROT     <= pprot_n;
         req_ack   <= ack_n;
         rsp_valid <= rspv_n;
         rsp_rdata <= rdata_n;
         rsp_err   <= err_n;
         ptr       <= ptr_n;
         owner     <= owner_n;
         tcnt      <= tcnt_n;
      end
   end

endmodule

// File: tb/tb_apb_rr_master.sv
// Purpose: self-checking bench for apb_rr_master with a behavioural APB slave and requester model.
// Latency: checks every cycle on the falling edge against transfer-level expectations.
// Backpressure: slave inserts programmable waits, errors or a stuck PREADY.

module tb_apb_rr_master;

   localparam int N = 3, AW = 12, DW = 32, SW = 4, PRW = 3, TMO = 4;

   logic            PCLK = 1'b0, PRESET = 1'b1;
   logic [N-1:0]    req_valid = '0, req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N*SW-1:0] req_strb = '0;
   logic [N*PRW-1:0] req_prot = '0;
   logic [N-1:0]    req_ack, rsp_valid;
   logic [DW-1:0]   rsp_rdata, PWDATA;
   logic            rsp_err, PSEL, PENABLE, PWRITE;
   logic [AW-1:0]   PADDR;
   logic [SW-1:0]   PSTRB;
   logic [PRW-1:0]  PPROT;
   logic [DW-1:0]   PRDATA = '0;
   logic            PREADY = 1'b0, PSLVERR = 1'b0;

   always #5 PCLK = ~PCLK;

   apb_rr_master #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
                   .PROT_WIDTH(PRW), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

   int passed = 0, total = 0, fails = 0;
   int cyc = 0, owner = 0, ack_cyc = 0, rsp_due = 0, ptr = 0, post_cyc = 0;
   bit outstanding = 0, rand_gap = 0, rand_slave = 0;
   int rq_state[N];   // 0 idle, 1 requesting, 2 acked and waiting for response
   int auto_n[N];
   logic            c_write[N];
   logic [AW-1:0]   c_addr[N];
   logic [DW-1:0]   c_wdata[N];
   logic [SW-1:0]   c_strb[N];
   logic [PRW-1:0]  c_prot[N];
   logic [DW-1:0]   ref_mem[16], slv_mem[16];
   int  tr_wait = 0, fix_wait = 0, acc_n = 0, pen_cnt = 0, last_rsp_cyc = 0;
   bit  tr_err = 0, tr_stuck = 0, fix_err = 0, fix_stuck = 0;
   logic [DW-1:0] last_rdata = '0;
   logic last_err = 1'b0, last_psel = 1'b0;
   int ack_log[$], ackcyc_log[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      if (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Behavioural APB slave: memory with programmable waits, error and stuck PREADY.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         if (!tr_stuck && acc_n == tr_wait) begin
            PREADY  = 1'b1;
            PSLVERR = tr_err || (!PWRITE && PSTRB != '0);
            PRDATA  = slv_mem[PADDR[3:0]];
            if (PWRITE && !PSLVERR)
               for (int b = 0; b < SW; b++)
                  if (PSTRB[b]) slv_mem[PADDR[3:0]][8*b +: 8] = PWDATA[8*b +: 8];
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
         end
         acc_n++;
      end else begin
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         PRDATA  = $urandom;
         acc_n   = 0;
      end
   end

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]              = (rq_state[i] == 1);
         req_write[i]              = c_write[i];
         req_addr[i*AW +: AW]      = c_addr[i];
         req_wdata[i*DW +: DW]     = c_wdata[i];
         req_strb[i*SW +: SW]      = c_strb[i];
         req_prot[i*PRW +: PRW]    = c_prot[i];
      end
   endtask

   task automatic post(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [PRW-1:0] p);
      c_write[i] = w; c_addr[i] = a; c_wdata[i] = d; c_strb[i] = s; c_prot[i] = p;
      rq_state[i] = 1;
      drive_inputs();
   endtask

   // One clock of checking against the transfer-level model, then new requester stimulus.
   task automatic cycle();
      logic [N-1:0]  exp_rsp, exp_ack;
      logic [DW-1:0] exp_rd;
      logic          exp_err, exp_pen;
      int            win, idx;
      @(negedge PCLK);
      cyc++;
      exp_rsp = '0;
      if (outstanding && cyc == rsp_due) exp_rsp[owner] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (outstanding && cyc == rsp_due) begin
         exp_err = tr_stuck ? 1'b1 : tr_err;
         exp_rd  = (c_write[owner] || tr_stuck) ? '0 : ref_mem[c_addr[owner][3:0]];
         chk("rsp_err", rsp_err, exp_err);
         chk("rsp_rdata", rsp_rdata, exp_rd);
         if (c_write[owner] && !exp_err)
            for (int b = 0; b < SW; b++)
               if (c_strb[owner][b]) ref_mem[c_addr[owner][3:0]][8*b +: 8] = c_wdata[owner][8*b +: 8];
         last_rdata = rsp_rdata; last_err = rsp_err; last_psel = PSEL; last_rsp_cyc = cyc;
         outstanding = 0;
         rq_state[owner] = 0;
      end
      win = -1;
      if (!outstanding)
         for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (win < 0 && rq_state[idx] == 1) win = idx;
         end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("req_ack", req_ack, exp_ack);
      if (win >= 0) begin
         outstanding = 1; owner = win; ack_cyc = cyc; ptr = (win + 1) % N;
         rq_state[win] = 2;
         if (rand_slave) begin
            tr_wait = $urandom_range(0, 3); tr_err = ($urandom_range(0, 4) == 0); tr_stuck = ($urandom_range(0, 7) == 0);
         end else begin
            tr_wait = fix_wait; tr_err = fix_err; tr_stuck = fix_stuck;
         end
         rsp_due = cyc + 2 + (tr_stuck ? TMO - 1 : tr_wait);
         pen_cnt = 0;
         ack_log.push_back(win);
         ackcyc_log.push_back(cyc);
      end
      exp_pen = outstanding && (cyc > ack_cyc);
      chk("psel", PSEL, outstanding);
      chk("penable", PENABLE, exp_pen);
      if (outstanding) begin
         chk("paddr", PADDR, c_addr[owner]);
         chk("pwrite", PWRITE, c_write[owner]);
         chk("pstrb", PSTRB, (c_write[owner] ? c_strb[owner] : 4'h0));
         chk("pprot", PPROT, c_prot[owner]);
         if (c_write[owner]) chk("pwdata", PWDATA, c_wdata[owner]);
      end
      if (PENABLE) pen_cnt++;
      for (int i = 0; i < N; i++)
         if (rq_state[i] == 0 && auto_n[i] > 0 && (!rand_gap || $urandom_range(0, 2) == 0)) begin
            c_write[i] = 1'($urandom_range(0, 1)); c_addr[i] = AW'($urandom_range(0, 15));
            c_wdata[i] = $urandom; c_strb[i] = SW'($urandom_range(0, 15)); c_prot[i] = PRW'($urandom_range(0, 7));
            rq_state[i] = 1;
            auto_n[i]--;
         end
      drive_inputs();
   endtask

   initial begin
      int busy;
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
      for (int i = 0; i < N; i++) begin
         rq_state[i] = 0; auto_n[i] = 0; c_write[i] = 0; c_addr[i] = '0; c_wdata[i] = '0; c_strb[i] = '0; c_prot[i] = '0;
      end
      drive_inputs();
      #1;
      chk("reset_outputs", {req_ack, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}, '0);
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;

      // Write then read back through requester 0.
      post(0, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 3'd0);
      post_cyc = cyc;
      repeat (5) cycle();
      chk("wr_latency", last_rsp_cyc - post_cyc, 3);
      chk("wr_err", last_err, 1'b0);
      post(0, 1'b0, 12'h005, 32'h12345678, 4'hF, 3'd0);
      post_cyc = cyc;
      repeat (5) cycle();
      chk("rd_latency", last_rsp_cyc - post_cyc, 3);
      chk("rd_data", last_rdata, 32'hDEADBEEF);
      chk("rd_err", last_err, 1'b0);

      // Read with non-zero requested strobes from requester 1.
      post(1, 1'b0, 12'h007, 32'h0, 4'hF, 3'd2);
      repeat (5) cycle();
      chk("rdstrb_err", last_err, 1'b0);

      // Contention: two requesters re-requesting as soon as each response lands.
      ack_log.delete(); ackcyc_log.delete();
      auto_n[0] = 4; auto_n[1] = 4;
      repeat (22) cycle();
      chk("cont_count", ack_log.size(), 8);
      for (int k = 0; k < 8 && k < ack_log.size(); k++) begin
         chk("cont_order", ack_log[k], k % 2);
         if (k > 0) chk("cont_gap", ackcyc_log[k] - ackcyc_log[k-1], 2);
      end

      // Three wait states then an error response.
      fix_wait = 3; fix_err = 1;
      post(0, 1'b0, 12'h005, 32'h0, 4'h0, 3'd1);
      repeat (8) cycle();
      chk("wait_penable", pen_cnt, 4);
      chk("wait_err", last_err, 1'b1);

      // Stuck PREADY forces a timeout completion.
      fix_wait = 0; fix_err = 0; fix_stuck = 1;
      post(1, 1'b1, 12'h009, 32'hCAFEF00D, 4'hF, 3'd1);
      repeat (8) cycle();
      chk("tmo_penable", pen_cnt, 4);
      chk("tmo_err", last_err, 1'b1);
      chk("tmo_rdata", last_rdata, 32'h0);
      chk("tmo_psel", last_psel, 1'b0);
      fix_stuck = 0;

      // Randomized traffic from all requesters with random slave behaviour.
      rand_slave = 1; rand_gap = 1;
      for (int i = 0; i < N; i++) auto_n[i] = 25;
      busy = 1;
      for (int c = 0; c < 3000 && busy != 0; c++) begin
         cycle();
         busy = outstanding ? 1 : 0;
         for (int i = 0; i < N; i++) busy += auto_n[i] + rq_state[i];
      end
      chk("rand_drain", busy, 0);

      // Asynchronous reset in the middle of ACCESS.
      rand_slave = 0; rand_gap = 0; fix_stuck = 1;
      post(0, 1'b0, 12'h003, 32'h0, 4'h0, 3'd0);
      cycle();
      cycle();
      #1 PRESET = 1'b1;
      #1;
      chk("rst_async", {req_ack, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}, '0);
      @(posedge PCLK);
      #1;
      chk("rst_hold", {req_ack, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}, '0);
      outstanding = 0; ptr = 0; fix_stuck = 0;
      for (int i = 0; i < N; i++) begin rq_state[i] = 0; auto_n[i] = 0; end
      drive_inputs();
      @(negedge PCLK);
      PRESET = 1'b0;
      ack_log.delete(); ackcyc_log.delete();
      post(1, 1'b0, 12'h005, 32'h0, 4'h0, 3'd0);
      post(0, 1'b0, 12'h005, 32'h0, 4'h0, 3'd0);
      repeat (8) cycle();
      chk("rst_acks", ack_log.size(), 2);
      if (ack_log.size() > 0) chk("rst_ptr", ack_log[0], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
